mips_ifetch: RTL and testbench

Instruction fetch unit for the single-issue MIPS core. Owns the program counter, issues word reads to instruction memory over a req/ack handshake, and registers each returned 32-bit instruction into an output slot. The slot is split into R-type fields, and `op_code`/`func` feed the `cont` control decoder directly. Supports a downstream stall and a branch/jump redirect.

---
 rtl/mips_pkg.sv | 28 ++
 rtl/instr_fields.sv | 26 ++
 rtl/mips_ifetch.sv | 122 ++++++++++++
 tb/tb_mips_ifetch.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: opcode/function constants, fetch FSM encoding,
// R-type field layout and fetch-unit defaults.
package mips_pkg;

    localparam int unsigned ADDR_W_DEF   = 32;
    localparam int unsigned INSTR_W      = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_SLL   = 6'b000000;

    typedef enum logic {
        ST_REQ   = 1'b0,
        ST_VALID = 1'b1
    } ifetch_state_t;

    typedef struct packed {
        logic [5:0] op_code;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
        logic [4:0] shamt;
        logic [5:0] func;
    } rtype_t;

endpackage

// File: rtl/instr_fields.sv
// Splits a 32-bit MIPS instruction word into its R-type and immediate fields.
module instr_fields
    import mips_pkg::*;
(
    input  logic [INSTR_W-1:0] instr,
    output logic [5:0]         op_code,
    output logic [4:0]         rs,
    output logic [4:0]         rt,
    output logic [4:0]         rd,
    output logic [4:0]         shamt,
    output logic [5:0]         func,
    output logic [15:0]        imm
);

    rtype_t r;

    assign r       = rtype_t'(instr);
    assign op_code = r.op_code;
    assign rs      = r.rs;
    assign rt      = r.rt;
    assign rd      = r.rd;
    assign shamt   = r.shamt;
    assign func    = r.func;
    assign imm     = instr[15:0];

endmodule

// File: rtl/mips_ifetch.sv
// Instruction fetch unit: owns the PC, fetches over a req/ack handshake and
// holds one instruction in an output slot with stall and redirect support.
module mips_ifetch
    import mips_pkg::*;
#(
    parameter int unsigned       ADDR_W   = ADDR_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
)
(
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              instr_valid,
    output logic [ADDR_W-1:0] instr_pc,
    output logic [5:0]        op_code,
    output logic [4:0]        rs,
    output logic [4:0]        rt,
    output logic [4:0]        rd,
    output logic [4:0]        shamt,
    output logic [5:0]        func,
    output logic [15:0]       imm
);

    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

    ifetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [ADDR_W-1:0]  fetch_addr_q, fetch_addr_d;
    logic [INSTR_W-1:0] slot_q, slot_d;
    logic [ADDR_W-1:0]  slot_pc_q, slot_pc_d;
    logic               drop_q, drop_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_REQ;
            pc_q         <= RESET_PC + PC_STEP;
            fetch_addr_q <= RESET_PC;
            slot_q       <= '0;
            slot_pc_q    <= '0;
            drop_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            fetch_addr_q <= fetch_addr_d;
            slot_q       <= slot_d;
            slot_pc_q    <= slot_pc_d;
            drop_q       <= drop_d;
        end
    end

    // pc always names the next address to fetch once the slot is consumed
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        fetch_addr_d = fetch_addr_q;
        slot_d       = slot_q;
        slot_pc_d    = slot_pc_q;
        drop_d       = drop_q;

        case (state_q)
            ST_REQ: begin
                if (imem_ack) begin
                    if (redirect_valid) begin
                        fetch_addr_d = redirect_pc;
                        pc_d         = redirect_pc + PC_STEP;
                        drop_d       = 1'b0;
                    end else if (drop_q) begin
                        fetch_addr_d = pc_q;
                        pc_d         = pc_q + PC_STEP;
                        drop_d       = 1'b0;
                    end else begin
                        slot_d    = imem_rdata;
                        slot_pc_d = fetch_addr_q;
                        state_d   = ST_VALID;
                    end
                end else if (redirect_valid) begin
                    // address must stay stable until ack; refetch target afterwards
                    pc_d   = redirect_pc;
                    drop_d = 1'b1;
                end
            end
            ST_VALID: begin
                if (redirect_valid) begin
                    slot_d       = '0;
                    slot_pc_d    = '0;
                    fetch_addr_d = redirect_pc;
                    pc_d         = redirect_pc + PC_STEP;
                    state_d      = ST_REQ;
                end else if (!stall) begin
                    slot_d       = '0;
                    slot_pc_d    = '0;
                    fetch_addr_d = pc_q;
                    pc_d         = pc_q + PC_STEP;
                    state_d      = ST_REQ;
                end
            end
        endcase
    end

    assign imem_req    = (state_q == ST_REQ);
    assign instr_valid = (state_q == ST_VALID);
    assign imem_addr   = fetch_addr_q;
    assign instr_pc    = slot_pc_q;

    instr_fields u_fields (
        .instr   (slot_q),
        .op_code (op_code),
        .rs      (rs),
        .rt      (rt),
        .rd      (rd),
        .shamt   (shamt),
        .func    (func),
        .imm     (imm)
    );

endmodule

// File: tb/tb_mips_ifetch.sv
// Randomized bench for mips_ifetch against a program-order reference model
// with a variable-latency instruction memory.
module tb_mips_ifetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        instr_valid;
    logic [31:0] instr_pc;
    logic [5:0]  op_code;
    logic [4:0]  rs, rt, rd, shamt;
    logic [5:0]  func;
    logic [15:0] imm;

    int n_tests = 0;
    int n_fail  = 0;

    // memory model and reference state
    int          lat_min = 0;
    int          lat_max = 0;
    int          cur_lat = 0;
    int          wait_cnt = 0;
    logic [31:0] exp_next = 32'h0;
    int          delivered = 0;

    mips_ifetch dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_pc       (instr_pc),
        .op_code        (op_code),
        .rs             (rs),
        .rt             (rt),
        .rd             (rd),
        .shamt          (shamt),
        .func           (func),
        .imm            (imm)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0)   return 32'h0000_0020;
        if (a == 32'h100) return 32'h0000_0022;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] dut_word();
        return {op_code, rs, rt, rd, shamt, func};
    endfunction

    task automatic set_lat(input int n);
        lat_min = n;
        lat_max = n;
        if (wait_cnt == 0) cur_lat = n;
    endtask

    // One clock: drive inputs, play memory, predict, advance, compare.
    task automatic step(input logic st, input logic rv, input logic [31:0] rpc);
        logic        cur_valid, cur_req, e_hold, e_new, e_clear, e_fresh;
        logic [31:0] cur_addr, cur_pc, cur_word, w;
        cur_valid = instr_valid;
        cur_req   = imem_req;
        cur_addr  = imem_addr;
        cur_pc    = instr_pc;
        cur_word  = dut_word();

        stall          = st;
        redirect_valid = rv;
        redirect_pc    = rpc;
        if (imem_req) begin
            if (wait_cnt >= cur_lat) begin
                imem_ack   = 1'b1;
                imem_rdata = mem_word(imem_addr);
                wait_cnt   = 0;
                cur_lat    = $urandom_range(lat_max, lat_min);
            end else begin
                imem_ack   = 1'b0;
                imem_rdata = 32'hDEAD_BEEF;
                wait_cnt++;
            end
        end else begin
            imem_ack   = 1'b0;
            imem_rdata = 32'hDEAD_BEEF;
            wait_cnt   = 0;
        end

        e_hold  = 1'b0;
        e_new   = 1'b0;
        e_clear = 1'b0;
        if (rv) begin
            e_clear  = cur_valid;
            exp_next = rpc;
        end else if (cur_valid) begin
            if (st) e_hold = 1'b1;
            else    exp_next = cur_pc + 32'd4;
        end else begin
            // only a response for the address the program wants next is delivered
            e_new = imem_ack && (cur_addr == exp_next);
        end
        e_fresh = !cur_req || imem_ack;

        @(posedge clk);
        #1;
        check("instr_valid", 32'(instr_valid), 32'(e_hold || e_new));
        check("imem_req", 32'(imem_req), 32'(!(e_hold || e_new)));
        if (e_hold) begin
            check("hold_pc", instr_pc, cur_pc);
            check("hold_word", dut_word(), cur_word);
        end
        if (e_new) begin
            w = mem_word(exp_next);
            delivered++;
            check("instr_pc", instr_pc, exp_next);
            check("fields", dut_word(), w);
            check("op_code", 32'(op_code), w >> 26);
            check("func", 32'(func), w & 32'h3F);
            check("imm", 32'(imm), w & 32'hFFFF);
        end
        if (e_clear) begin
            check("clear_pc", instr_pc, 32'h0);
            check("clear_word", dut_word(), 32'h0);
        end
        if (imem_req) check("imem_addr", imem_addr, e_fresh ? exp_next : cur_addr);
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        imem_ack       = 1'b0;
        wait_cnt       = 0;
        cur_lat        = $urandom_range(lat_max, lat_min);
        exp_next       = 32'h0;
        #1;
        check("rst_valid", 32'(instr_valid), 32'h0);
        check("rst_pc", instr_pc, 32'h0);
        check("rst_word", dut_word(), 32'h0);
        check("rst_imm", 32'(imm), 32'h0);
        check("rst_req", 32'(imem_req), 32'h1);
        check("rst_addr", imem_addr, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic wait_valid(input int budget, output int cycles);
        cycles = 0;
        while (!instr_valid && cycles < budget) begin
            step(1'b0, 1'b0, 32'h0);
            cycles++;
        end
        if (!instr_valid) check("wait_valid_timeout", 32'h0, 32'h1);
    endtask

    initial begin
        int          c;
        int          cnt;
        int          start_del;
        logic        st, rv;
        logic [31:0] rpc;

        @(posedge clk);
        #1;
        set_lat(0);
        do_reset();

        // zero-wait: valid one cycle after release
        step(1'b0, 1'b0, 32'h0);
        check("first_valid", 32'(instr_valid), 32'h1);
        check("first_pc", instr_pc, 32'h0);
        check("first_op", 32'(op_code), 32'h0);
        check("first_func", 32'(func), 32'h20);

        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 32'h0);
            check("stall_req", 32'(imem_req), 32'h0);
            check("stall_func", 32'(func), 32'h20);
        end

        // consume, then redirect one cycle before a 3-cycle ack
        set_lat(3);
        step(1'b0, 1'b0, 32'h0);
        check("next_addr", imem_addr, 32'h4);
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b1, 32'h40);
        wait_valid(20, c);
        check("redir_pc", instr_pc, 32'h40);

        // redirect under stall in VALID clears slot immediately
        step(1'b1, 1'b1, 32'h100);
        check("rs_valid", 32'(instr_valid), 32'h0);
        check("rs_addr", imem_addr, 32'h100);
        check("rs_func", 32'(func), 32'h0);
        wait_valid(20, c);
        check("lat3_cycles", 32'(c), 32'd4);
        check("lat3_func", 32'(func), 32'h22);

        // PC wrap
        set_lat(0);
        step(1'b0, 1'b1, 32'hFFFF_FFFC);
        wait_valid(10, c);
        check("wrap_pc", instr_pc, 32'hFFFF_FFFC);
        step(1'b0, 1'b0, 32'h0);
        check("wrap_addr", imem_addr, 32'h0);
        wait_valid(10, c);
        check("wrap_next_pc", instr_pc, 32'h0);

        // zero-wait throughput: one instruction per two cycles
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b0, 32'h0);
            cnt += int'(instr_valid);
        end
        check("throughput", 32'(cnt), 32'd10);

        // reset in the middle of a pending request
        set_lat(3);
        if (instr_valid) step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        lat_min = 0;
        lat_max = 3;
        do_reset();

        // random traffic
        start_del = delivered;
        for (int i = 0; i < 3000; i++) begin
            st  = ($urandom_range(99, 0) < 30);
            rv  = ($urandom_range(99, 0) < 5);
            rpc = $urandom() & 32'hFFFF_FFFC;
            while (rpc == imem_addr) rpc = $urandom() & 32'hFFFF_FFFC;
            step(st, rv, rpc);
        end
        check("progress", 32'(delivered - start_del >= 100), 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
